// File: rtl/uart_rx_axis_bridge.sv
// uart_rx_axis_bridge
// Serial UART receiver feeding an AXI-Stream master through a one-entry staging
// register and a first-word-fall-through FIFO. A word is marked last when the line
// stays idle for IDLE_BITS bit-times after it was received.
// Build option: define UART_RX_PARITY_EN for start + WIDTH data + even parity + stop
// framing; without it the frame is 8N1-style and parity_err is tied low.
module uart_rx_axis_bridge #(
    parameter int CLK_RATE  = 50000000,
    parameter int BAUD      = 115200,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int IDLE_BITS = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_rx,
    output logic [WIDTH-1:0]         m_axis_data,
    output logic                     m_axis_valid,
    input  logic                     m_axis_ready,
    output logic                     m_axis_last,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int BAUD_DIV = CLK_RATE / BAUD;
    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam int IDLE_MAX = IDLE_BITS * BAUD_DIV - 1;
    localparam int AW       = $clog2(DEPTH);
    localparam int CNTW     = AW + 1;
    localparam int CW       = $clog2(BAUD_DIV + 1);
    localparam int BW       = $clog2(WIDTH + 1);
    localparam int IW       = $clog2(IDLE_MAX + 1);
    localparam int unsigned DEPTH_U = DEPTH;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    // Line synchronizer
    logic sync1_q;
    logic sync2_q;
    logic rxs;

    // Receive FSM state
    state_t           state_q;
    logic [CW-1:0]    baud_cnt_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic             frame_err_q;
    logic             bit_tick;
    logic             word_good;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q;
    logic             parity_err_q;
`endif

    // Staging register and idle timer
    logic [WIDTH-1:0] stg_data_q;
    logic             stg_vld_q;
    logic [IW-1:0]    idle_cnt_q;
    logic             timeout;

    // FIFO
    logic [WIDTH:0]   mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CNTW-1:0]  count_q;
    logic [CNTW-1:0]  count_d;
    logic             overflow_q;
    logic             push_d;
    logic             push_last_d;
    logic             push_ok;
    logic             pop;

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
        end
    end

    assign rxs      = sync2_q;
    assign bit_tick = (baud_cnt_q == CW'(BAUD_DIV - 1));

`ifdef UART_RX_PARITY_EN
    assign word_good = (state_q == ST_STOP) && bit_tick && rxs && !par_bad_q;
`else
    assign word_good = (state_q == ST_STOP) && bit_tick && rxs;
`endif

    // Receive FSM: start validation, mid-bit sampling, parity/stop checks, error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (!rxs) begin
                        state_q    <= ST_START;
                        baud_cnt_q <= '0;
                    end
                end
                ST_START: begin
                    if (baud_cnt_q == CW'(HALF_DIV - 1)) begin
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        baud_cnt_q <= '0;
                        shift_q    <= {rxs, shift_q[WIDTH-1:1]};
                        bit_cnt_q  <= bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BW'(WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        baud_cnt_q <= '0;
                        par_bad_q  <= (^shift_q) ^ rxs;
                        state_q    <= ST_STOP;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_tick) begin
                        baud_cnt_q <= '0;
                        if (!rxs) begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_WAIT_HIGH;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            if (par_bad_q) begin
                                parity_err_q <= 1'b1;
                            end
`endif
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rxs) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The FIFO is always fed from the staging register: either the previous word
    // displaced by a new good word (last=0) or the held word closed by idle timeout (last=1).
    assign timeout     = (state_q == ST_IDLE) && stg_vld_q && (idle_cnt_q == IW'(IDLE_MAX));
    assign push_d      = (word_good && stg_vld_q) || timeout;
    assign push_last_d = timeout;

    // Staging register and idle timer that closes a packet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_data_q <= '0;
            stg_vld_q  <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            if (word_good) begin
                stg_data_q <= shift_q;
                stg_vld_q  <= 1'b1;
            end else if (timeout) begin
                stg_vld_q <= 1'b0;
            end
            if ((state_q != ST_IDLE) || timeout) begin
                idle_cnt_q <= '0;
            end else if (stg_vld_q) begin
                idle_cnt_q <= idle_cnt_q + IW'(1);
            end
        end
    end

    assign pop     = m_axis_valid && m_axis_ready;
    assign push_ok = push_d && ((count_q != CNTW'(DEPTH)) || pop);

    // Occupancy next-state: simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CNTW'(1);
        end
    end

    // FIFO storage: {last, data} per entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH_U; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wptr_q] <= {push_last_d, stg_data_q};
        end
    end

    // FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q    <= count_d;
            overflow_q <= push_d && !push_ok;
        end
    end

    assign m_axis_data  = mem_q[rptr_q][WIDTH-1:0];
    assign m_axis_last  = mem_q[rptr_q][WIDTH];
    assign m_axis_valid = (count_q != '0);
    assign fifo_count   = count_q;
    assign frame_err    = frame_err_q;
    assign overflow     = overflow_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = parity_err_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_axis_bridge.sv
// tb_uart_rx_axis_bridge
// Drives serial frames into the bridge and checks every AXI-Stream beat against a
// queue-based model of staging/timeout/FIFO behaviour, plus error pulse counts.
module tb_uart_rx_axis_bridge;

    localparam int CLK_RATE  = 1000;
    localparam int BAUD      = 100;
    localparam int BD        = CLK_RATE / BAUD;
    localparam int DEPTH     = 16;
    localparam int IDLE_BITS = 10;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       m_axis_ready = 1'b1;
    logic [7:0] m_axis_data;
    logic       m_axis_valid;
    logic       m_axis_last;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic [4:0] fifo_count;

    uart_rx_axis_bridge #(
        .CLK_RATE  (CLK_RATE),
        .BAUD      (BAUD),
        .WIDTH     (8),
        .DEPTH     (DEPTH),
        .IDLE_BITS (IDLE_BITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx      (uart_rx),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_last  (m_axis_last),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [8:0] exp_q [$];
    logic [7:0] m_stg = 8'h00;
    bit         m_stg_vld = 1'b0;
    int         exp_par = 0, exp_frame = 0, exp_ovf = 0;

    // Observed state
    int         got_par = 0, got_frame = 0, got_ovf = 0;
    int         beats = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_last = 1'b0;

    bit         ready_rand = 1'b0;
    logic       ready_fixed = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void model_push(input logic [7:0] d, input logic l);
        if (exp_q.size() >= DEPTH) exp_ovf++;
        else exp_q.push_back({l, d});
    endfunction

    function automatic void model_good(input logic [7:0] d);
        if (m_stg_vld) model_push(m_stg, 1'b0);
        m_stg     = d;
        m_stg_vld = 1'b1;
    endfunction

    function automatic void model_timeout();
        if (m_stg_vld) begin
            model_push(m_stg, 1'b1);
            m_stg_vld = 1'b0;
        end
    endfunction

    task automatic drive_bit(input logic b);
        uart_rx = b;
        repeat (BD) @(negedge clk);
    endtask

    // Model is updated at frame start, which is always ahead of the DUT push
    task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_bad);
        bit pf;
        pf = PAR && par_flip;
        if (stop_bad) exp_frame++;
        else if (pf) exp_par++;
        else model_good(d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR) drive_bit((^d) ^ pf);
        if (stop_bad) begin
            drive_bit(1'b0);
            drive_bit(1'b0);
        end else begin
            drive_bit(1'b1);
        end
    endtask

    // Gaps of 12+ bit-times close the packet; gaps up to 3 never do
    task automatic line_idle(input int n);
        if (n >= IDLE_BITS + 2) model_timeout();
        uart_rx = 1'b1;
        repeat (n * BD) @(negedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 entries left", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"},  m_axis_data, 0);
        check({tag, "_valid"}, m_axis_valid, 0);
        check({tag, "_last"},  m_axis_last, 0);
        check({tag, "_perr"},  parity_err, 0);
        check({tag, "_ferr"},  frame_err, 0);
        check({tag, "_ovf"},   overflow, 0);
        check({tag, "_count"}, fifo_count, 0);
    endtask

    // Ready driver: fixed level or random per cycle
    initial begin
        forever begin
            @(negedge clk);
            m_axis_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    // Compare process: beats vs model, AXIS hold rule, pulse widths
    initial begin
        logic       pv, pr, pl, pp, pf, po;
        logic [7:0] pd;
        logic [8:0] e;
        bit         have_prev;
        have_prev = 0;
        pv = 0; pr = 0; pl = 0; pp = 0; pf = 0; po = 0; pd = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                have_prev = 0;
                pp = 0; pf = 0; po = 0;
            end else begin
                if (parity_err) begin got_par++;   check("parity_err_single", pp, 0); end
                if (frame_err)  begin got_frame++; check("frame_err_single", pf, 0);  end
                if (overflow)   begin got_ovf++;   check("overflow_single", po, 0);   end
                check("valid_vs_count", m_axis_valid, fifo_count != 0);
                if (have_prev && pv && !pr) begin
                    check("hold_valid", m_axis_valid, 1);
                    check("hold_data", m_axis_data, pd);
                    check("hold_last", m_axis_last, pl);
                end
                if (m_axis_valid && m_axis_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat actual=%0h/%0b required=no beat",
                                 m_axis_data, m_axis_last);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", m_axis_data, e[7:0]);
                        check("beat_last", m_axis_last, e[8]);
                    end
                    beats++;
                    last_data = m_axis_data;
                    last_last = m_axis_last;
                end
                pv = m_axis_valid; pr = m_axis_ready; pd = m_axis_data; pl = m_axis_last;
                pp = parity_err; pf = frame_err; po = overflow;
                have_prev = 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         b0, f0, o0, g, r;
        logic [7:0] d;
        bit         sb, pf;

        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;
        line_idle(2);

        // Single word closed by idle
        b0 = beats;
        send_frame(8'h55, 0, 0);
        line_idle(12);
        wait_drain();
        check("t1_beats", beats - b0, 1);
        check("t1_data", last_data, 8'h55);
        check("t1_last", last_last, 1);

        // Two back-to-back words
        b0 = beats;
        send_frame(8'hA5, 0, 0);
        send_frame(8'h3C, 0, 0);
        line_idle(12);
        wait_drain();
        check("t2_beats", beats - b0, 2);
        check("t2_data", last_data, 8'h3C);
        check("t2_last", last_last, 1);

`ifdef UART_RX_PARITY_EN
        // Bad parity: pulse, no beat
        b0 = beats;
        f0 = got_par;
        send_frame(8'h0F, 1, 0);
        line_idle(12);
        check("t3_perr", got_par - f0, 1);
        check("t3_count", fifo_count, 0);
        check("t3_beats", beats - b0, 0);
`endif

        // Frame error, then a good word
        b0 = beats;
        f0 = got_frame;
        send_frame(8'h81, 0, 1);
        line_idle(2);
        send_frame(8'h22, 0, 0);
        line_idle(12);
        wait_drain();
        check("t4_ferr", got_frame - f0, 1);
        check("t4_beats", beats - b0, 1);
        check("t4_data", last_data, 8'h22);
        check("t4_last", last_last, 1);

        // Overflow with ready held low
        ready_fixed = 1'b0;
        o0 = got_ovf;
        for (int k = 0; k < 18; k++) send_frame(8'(k), 0, 0);
        line_idle(12);
        check("ovf_count", fifo_count, 16);
        check("ovf_pulses", got_ovf - o0, 2);
        b0 = beats;
        ready_fixed = 1'b1;
        wait_drain();
        check("ovf_beats", beats - b0, 16);
        check("ovf_tail_data", last_data, 8'h0F);
        check("ovf_tail_last", last_last, 0);

        // Glitch shorter than half a bit
        uart_rx = 1'b0;
        repeat (BD / 4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * BD) @(negedge clk);
        check("glitch_count", fifo_count, 0);
        send_frame(8'hC3, 0, 0);
        line_idle(12);
        wait_drain();
        check("glitch_next_data", last_data, 8'hC3);
        check("glitch_next_last", last_last, 1);

        // Reset in the middle of a frame
        ready_fixed = 1'b0;
        send_frame(8'h5A, 0, 0);
        line_idle(12);
        #1;
        check("prerst_count", fifo_count, 1);
        check("prerst_data", m_axis_data, 8'h5A);
        check("prerst_last", m_axis_last, 1);
        @(negedge clk);
        send_frame(8'h77, 0, 0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        exp_q.delete();
        m_stg_vld = 1'b0;
        uart_rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ready_fixed = 1'b1;
        line_idle(2);
        send_frame(8'h42, 0, 0);
        line_idle(12);
        wait_drain();
        check("postrst_data", last_data, 8'h42);
        check("postrst_last", last_last, 1);

        // Randomized traffic with random back-pressure
        ready_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            d  = 8'($urandom);
            r  = int'($urandom_range(0, 9));
            sb = (r == 0);
            pf = PAR && (r == 1);
            send_frame(d, pf, sb);
            if (sb) g = 1 + int'($urandom_range(0, 2));
            else if ($urandom_range(0, 3) == 0) g = 12 + int'($urandom_range(0, 3));
            else g = int'($urandom_range(0, 3));
            line_idle(g);
        end
        line_idle(12);
        wait_drain();
        ready_rand = 1'b0;
        repeat (4) @(negedge clk);
        #1;

        check("total_parity_pulses", got_par, exp_par);
        check("total_frame_pulses", got_frame, exp_frame);
        check("total_overflow_pulses", got_ovf, exp_ovf);
        check("final_queue", exp_q.size(), 0);
        check("final_count", fifo_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
